// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: collects half-unit coins, vends at PRICE,
// pays change one half-unit pulse at a time, then sounds a completion beep.
// Every output is a register (led is decoded from registered state/credit).
module vend_txn_ctrl #(
   parameter int PRICE      = 5,
   parameter int MAX_CREDIT = 15,
   parameter int IDLE_TO    = 1000,
   parameter int PAY_GAP    = 4,
   parameter int BEEP_CYC   = 8
) (
   input  logic       clk,
   input  logic       rst_n,      // active-high despite the name
   input  logic       coin_half,
   input  logic       coin_one,
   input  logic       buy_p,
   input  logic       cancel_p,
   output logic [3:0] credit,
   output logic       dispense,
   output logic       change_p,
   output logic       reject_p,
   output logic       beep,
   output logic [3:0] led
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_VEND,
      S_CHANGE,
      S_DONE
   } state_t;

   // One shared counter: inactivity in COLLECT, pulse spacing in CHANGE,
   // beep length in DONE. Sized for the largest of the three.
   localparam int CNT_MAX = (IDLE_TO > PAY_GAP) ?
                            ((IDLE_TO > BEEP_CYC) ? IDLE_TO : BEEP_CYC) :
                            ((PAY_GAP > BEEP_CYC) ? PAY_GAP : BEEP_CYC);
   localparam int CNT_W = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

   localparam logic [4:0]       MAX_C     = 5'(MAX_CREDIT);
   localparam logic [3:0]       PRICE_C   = 4'(PRICE);
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TO - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(PAY_GAP - 1);
   localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYC - 1);

   state_t           state_q, state_d;
   logic [3:0]       credit_q, credit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dispense_q, dispense_d;
   logic             change_q, change_d;
   logic             reject_q, reject_d;
   logic             beep_q, beep_d;

   logic             coin_any;
   logic             coin_dup;
   logic [4:0]       coin_total;
   logic             coin_fits;

   // Credit plus the winning coin, one bit wider so overflow is visible.
   function automatic logic [4:0] coin_sum(input logic [3:0] c, input logic one);
      return {1'b0, c} + (one ? 5'd2 : 5'd1);
   endfunction

   // When both coins arrive together coin_one is the one considered.
   assign coin_any   = coin_half | coin_one;
   assign coin_dup   = coin_half & coin_one;
   assign coin_total = coin_sum(credit_q, coin_one);
   assign coin_fits  = (coin_total <= MAX_C);

   // State, credit, counter and registered pulse outputs.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q    <= S_IDLE;
         credit_q   <= '0;
         cnt_q      <= '0;
         dispense_q <= 1'b0;
         change_q   <= 1'b0;
         reject_q   <= 1'b0;
         beep_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         cnt_q      <= cnt_d;
         dispense_q <= dispense_d;
         change_q   <= change_d;
         reject_q   <= reject_d;
         beep_q     <= beep_d;
      end
   end

   // Next-state and next-output decode for the transaction sequence.
   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      cnt_d      = cnt_q;
      dispense_d = 1'b0;
      change_d   = 1'b0;
      reject_d   = 1'b0;
      beep_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (coin_any) begin
               reject_d = coin_dup | ~coin_fits;
               if (coin_fits) begin
                  credit_d = coin_total[3:0];
                  state_d  = S_COLLECT;
               end
            end
         end

         S_COLLECT: begin
            // Inactivity timer: any event restarts it, expiry refunds.
            if (coin_any || buy_p || cancel_p) begin
               cnt_d = '0;
            end else if (cnt_q == IDLE_LAST) begin
               state_d = S_CHANGE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end

            if (cancel_p) begin
               state_d  = S_CHANGE;
               reject_d = coin_any;
            end else if (buy_p && (credit_q >= PRICE_C)) begin
               state_d    = S_VEND;
               dispense_d = 1'b1;
               credit_d   = credit_q - PRICE_C;
               reject_d   = coin_any;
            end else if (coin_any) begin
               reject_d = coin_dup | ~coin_fits;
               if (coin_fits) begin
                  credit_d = coin_total[3:0];
               end
            end
         end

         S_VEND: begin
            // Credit was already reduced by PRICE on entry.
            reject_d = coin_any;
            cnt_d    = '0;
            if (credit_q != 4'd0) begin
               state_d = S_CHANGE;
            end else begin
               state_d = S_DONE;
               beep_d  = 1'b1;
            end
         end

         S_CHANGE: begin
            reject_d = coin_any;
            if (credit_q == 4'd0) begin
               state_d = S_DONE;
               beep_d  = 1'b1;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               change_d = 1'b1;
               credit_d = credit_q - 4'd1;
               if (credit_q == 4'd1) begin
                  state_d = S_DONE;
                  beep_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = GAP_LAST;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_DONE: begin
            reject_d = coin_any;
            credit_d = '0;
            if (cnt_q == BEEP_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d  = cnt_q + CNT_W'(1);
               beep_d = 1'b1;
            end
         end

         default: begin
            state_d  = S_IDLE;
            credit_d = '0;
            cnt_d    = '0;
         end
      endcase
   end

   assign credit   = credit_q;
   assign dispense = dispense_q;
   assign change_p = change_q;
   assign reject_p = reject_q;
   assign beep     = beep_q;
   assign led      = {state_q == S_DONE, state_q == S_CHANGE,
                      credit_q >= PRICE_C, state_q == S_COLLECT};

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Scenario bench for vend_txn_ctrl: each task drives a transaction and
// compares the registered outputs one cycle after each stimulus.
module tb_vend_txn_ctrl;

   localparam int PRICE    = 5;
   localparam int PAY_GAP  = 4;
   localparam int BEEP_CYC = 8;
   localparam int IDLE_TO  = 1000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       coin_half = 1'b0;
   logic       coin_one = 1'b0;
   logic       buy_p = 1'b0;
   logic       cancel_p = 1'b0;
   logic [3:0] credit;
   logic       dispense;
   logic       change_p;
   logic       reject_p;
   logic       beep;
   logic [3:0] led;

   int vectors = 0;
   int miscompares = 0;

   // in = {coin_half, coin_one, buy_p, cancel_p}
   // val = {credit[3:0], dispense, change_p, reject_p, beep, led[3:0]}
   typedef struct {
      string      name;
      logic [3:0] in;
      logic [11:0] val;
   } step_t;

   step_t exp_q[$];
   logic [11:0] obs;
   assign obs = {credit, dispense, change_p, reject_p, beep, led};

   always #5 clk = ~clk;

   vend_txn_ctrl #(
      .PRICE(PRICE), .MAX_CREDIT(15), .IDLE_TO(IDLE_TO),
      .PAY_GAP(PAY_GAP), .BEEP_CYC(BEEP_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .coin_half(coin_half), .coin_one(coin_one),
      .buy_p(buy_p), .cancel_p(cancel_p), .credit(credit), .dispense(dispense),
      .change_p(change_p), .reject_p(reject_p), .beep(beep), .led(led)
   );

   function automatic logic [11:0] ex(input logic [3:0] c, input logic d, input logic ch,
                                      input logic r, input logic b, input logic [3:0] l);
      return {c, d, ch, r, b, l};
   endfunction

   function automatic logic [3:0] led_col(input int c);
      return (c >= PRICE) ? 4'b0011 : 4'b0001;
   endfunction

   // Drive one cycle of stimulus, queue its expectation, land #1 after the edge.
   task automatic drive(input step_t st);
      {coin_half, coin_one, buy_p, cancel_p} = st.in;
      exp_q.push_back(st);
      @(posedge clk);
      #1;
      {coin_half, coin_one, buy_p, cancel_p} = 4'b0000;
   endtask

   // Run idle cycles until the controller is back in IDLE, gathering pulse stats.
   task automatic drain(output int pulses, output int first_at, output int min_gap,
                        output int max_gap, output int beeps, output int disp,
                        output bit timed_out);
      int last;
      pulses = 0; first_at = -1; min_gap = 1000; max_gap = 0;
      beeps = 0; disp = 0; timed_out = 1'b1; last = 0;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk);
         #1;
         if (change_p) begin
            if (pulses == 0) first_at = k;
            else begin
               if (k - last < min_gap) min_gap = k - last;
               if (k - last > max_gap) max_gap = k - last;
            end
            last = k;
            pulses++;
         end
         if (beep) beeps++;
         if (dispense) disp++;
         if (obs == 12'h000) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      step_t s[$];
      step_t e;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (obs !== 12'h000) begin
         miscompares++;
         $display("FAIL reset_state: got %h want 000", obs);
      end
      rst_n = 1'b0;
      s.push_back('{"idle_buy",    4'b0010, ex(0, 0, 0, 0, 0, 4'b0000)});
      s.push_back('{"idle_cancel", 4'b0001, ex(0, 0, 0, 0, 0, 4'b0000)});
      s.push_back('{"idle_quiet",  4'b0000, ex(0, 0, 0, 0, 0, 4'b0000)});
      foreach (s[i]) begin
         drive(s[i]);
         e = exp_q.pop_front();
         vectors++;
         if (obs !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
         end
      end
   endtask

   task automatic test_purchase_change();
      step_t s[$];
      step_t e;
      s.push_back('{"buy_c1_2",   4'b0100, ex(2, 0, 0, 0, 0, 4'b0001)});
      s.push_back('{"buy_c1_4",   4'b0100, ex(4, 0, 0, 0, 0, 4'b0001)});
      s.push_back('{"buy_c1_6",   4'b0100, ex(6, 0, 0, 0, 0, 4'b0011)});
      s.push_back('{"buy_vend",   4'b0010, ex(1, 1, 0, 0, 0, 4'b0000)});
      s.push_back('{"buy_chg_in", 4'b0000, ex(1, 0, 0, 0, 0, 4'b0100)});
      s.push_back('{"buy_chg_p",  4'b0000, ex(0, 0, 1, 0, 1, 4'b1000)});
      for (int i = 1; i < BEEP_CYC; i++)
         s.push_back('{"buy_beep", 4'b0000, ex(0, 0, 0, 0, 1, 4'b1000)});
      s.push_back('{"buy_idle",   4'b0000, ex(0, 0, 0, 0, 0, 4'b0000)});
      foreach (s[i]) begin
         drive(s[i]);
         e = exp_q.pop_front();
         vectors++;
         if (obs !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
         end
      end
   endtask

   task automatic test_dual_coin();
      step_t s[$];
      step_t e;
      int p, f, mn, mx, b, d;
      bit to;
      s.push_back('{"dual_c1",     4'b0100, ex(2, 0, 0, 0, 0, 4'b0001)});
      s.push_back('{"dual_ch",     4'b1000, ex(3, 0, 0, 0, 0, 4'b0001)});
      s.push_back('{"dual_both",   4'b1100, ex(5, 0, 0, 1, 0, 4'b0011)});
      s.push_back('{"dual_quiet",  4'b0000, ex(5, 0, 0, 0, 0, 4'b0011)});
      s.push_back('{"dual_cancel", 4'b0001, ex(5, 0, 0, 0, 0, 4'b0110)});
      s.push_back('{"dual_coin_in_chg", 4'b0100, ex(4, 0, 1, 1, 0, 4'b0100)});
      foreach (s[i]) begin
         drive(s[i]);
         e = exp_q.pop_front();
         vectors++;
         if (obs !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
         end
      end
      drain(p, f, mn, mx, b, d, to);
      vectors++;
      if (to !== 1'b0 || p != 4 || f != PAY_GAP || b != BEEP_CYC) begin
         miscompares++;
         $display("FAIL dual_drain: got to=%0d pulses=%0d first=%0d beeps=%0d want 0/4/%0d/%0d",
                  to, p, f, b, PAY_GAP, BEEP_CYC);
      end
   endtask

   task automatic test_overflow();
      step_t s[$];
      step_t e;
      int p, f, mn, mx, b, d;
      bit to;
      for (int i = 1; i <= 7; i++)
         s.push_back('{"ovf_c1", 4'b0100, ex(4'(2 * i), 0, 0, 0, 0, led_col(2 * i))});
      s.push_back('{"ovf_reject", 4'b0100, ex(14, 0, 0, 1, 0, 4'b0011)});
      s.push_back('{"ovf_cancel", 4'b0001, ex(14, 0, 0, 0, 0, 4'b0110)});
      foreach (s[i]) begin
         drive(s[i]);
         e = exp_q.pop_front();
         vectors++;
         if (obs !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
         end
      end
      drain(p, f, mn, mx, b, d, to);
      vectors++;
      if (to !== 1'b0 || p != 14 || f != 1 || b != BEEP_CYC) begin
         miscompares++;
         $display("FAIL ovf_drain: got to=%0d pulses=%0d first=%0d beeps=%0d want 0/14/1/%0d",
                  to, p, f, b, BEEP_CYC);
      end
      vectors++;
      if (mn != PAY_GAP || mx != PAY_GAP) begin
         miscompares++;
         $display("FAIL ovf_gap: got min=%0d max=%0d want %0d", mn, mx, PAY_GAP);
      end
   endtask

   task automatic test_ceiling();
      step_t s[$];
      step_t e;
      int p, f, mn, mx, b, d;
      bit to;
      for (int i = 1; i <= 7; i++)
         s.push_back('{"ceil_c1", 4'b0100, ex(4'(2 * i), 0, 0, 0, 0, led_col(2 * i))});
      s.push_back('{"ceil_half_15",  4'b1000, ex(15, 0, 0, 0, 0, 4'b0011)});
      s.push_back('{"ceil_half_rej", 4'b1000, ex(15, 0, 0, 1, 0, 4'b0011)});
      s.push_back('{"ceil_cancel",   4'b0001, ex(15, 0, 0, 0, 0, 4'b0110)});
      foreach (s[i]) begin
         drive(s[i]);
         e = exp_q.pop_front();
         vectors++;
         if (obs !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
         end
      end
      drain(p, f, mn, mx, b, d, to);
      vectors++;
      if (to !== 1'b0 || p != 15) begin
         miscompares++;
         $display("FAIL ceil_drain: got to=%0d pulses=%0d want 0/15", to, p);
      end
   endtask

   task automatic test_timeout();
      step_t s[$];
      step_t e;
      int p, f, mn, mx, b, d;
      bit to;
      s.push_back('{"to_c1_2", 4'b0100, ex(2, 0, 0, 0, 0, 4'b0001)});
      s.push_back('{"to_c1_4", 4'b0100, ex(4, 0, 0, 0, 0, 4'b0001)});
      s.push_back('{"to_buy_low", 4'b0010, ex(4, 0, 0, 0, 0, 4'b0001)});
      foreach (s[i]) begin
         drive(s[i]);
         e = exp_q.pop_front();
         vectors++;
         if (obs !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
         end
      end
      repeat (IDLE_TO - 1) @(posedge clk);
      #1;
      vectors++;
      if (obs !== ex(4, 0, 0, 0, 0, 4'b0001)) begin
         miscompares++;
         $display("FAIL to_early: got %h want %h", obs, ex(4, 0, 0, 0, 0, 4'b0001));
      end
      @(posedge clk);
      #1;
      vectors++;
      if (obs !== ex(4, 0, 0, 0, 0, 4'b0100)) begin
         miscompares++;
         $display("FAIL to_expire: got %h want %h", obs, ex(4, 0, 0, 0, 0, 4'b0100));
      end
      drain(p, f, mn, mx, b, d, to);
      vectors++;
      if (to !== 1'b0 || p != 4 || f != 1 || b != BEEP_CYC || d != 0) begin
         miscompares++;
         $display("FAIL to_drain: got to=%0d pulses=%0d first=%0d beeps=%0d disp=%0d want 0/4/1/%0d/0",
                  to, p, f, b, d, BEEP_CYC);
      end
   endtask

   task automatic test_buy_cancel();
      step_t s[$];
      step_t e;
      int p, f, mn, mx, b, d;
      bit to;
      for (int i = 1; i <= 3; i++)
         s.push_back('{"bc_c1", 4'b0100, ex(4'(2 * i), 0, 0, 0, 0, led_col(2 * i))});
      s.push_back('{"bc_both", 4'b0011, ex(6, 0, 0, 0, 0, 4'b0110)});
      foreach (s[i]) begin
         drive(s[i]);
         e = exp_q.pop_front();
         vectors++;
         if (obs !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
         end
      end
      drain(p, f, mn, mx, b, d, to);
      vectors++;
      if (to !== 1'b0 || p != 6 || d != 0 || b != BEEP_CYC) begin
         miscompares++;
         $display("FAIL bc_drain: got to=%0d pulses=%0d disp=%0d beeps=%0d want 0/6/0/%0d",
                  to, p, d, b, BEEP_CYC);
      end
   endtask

   task automatic test_reset_mid();
      step_t s[$];
      step_t e;
      int seen, extra, p, f, mn, mx, b, d;
      bit got, to;
      for (int i = 1; i <= 3; i++)
         s.push_back('{"rm_c1", 4'b0100, ex(4'(2 * i), 0, 0, 0, 0, led_col(2 * i))});
      s.push_back('{"rm_cancel", 4'b0001, ex(6, 0, 0, 0, 0, 4'b0110)});
      foreach (s[i]) begin
         drive(s[i]);
         e = exp_q.pop_front();
         vectors++;
         if (obs !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
         end
      end
      seen = 0;
      got = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         #1;
         if (change_p) seen++;
         if (seen == 2) begin
            got = 1'b1;
            break;
         end
      end
      vectors++;
      if (!got || credit !== 4'd4) begin
         miscompares++;
         $display("FAIL rm_two_pulses: got seen=%0d credit=%0d want 2/4", seen, credit);
      end
      #1 rst_n = 1'b1;
      #1;
      vectors++;
      if (obs !== 12'h000) begin
         miscompares++;
         $display("FAIL rm_async_clear: got %h want 000", obs);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      extra = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (change_p || obs !== 12'h000) extra++;
      end
      vectors++;
      if (extra != 0) begin
         miscompares++;
         $display("FAIL rm_after_release: got %0d active cycles want 0", extra);
      end
      s.delete();
      s.push_back('{"rm_resume", 4'b1000, ex(1, 0, 0, 0, 0, 4'b0001)});
      s.push_back('{"rm_cancel2", 4'b0001, ex(1, 0, 0, 0, 0, 4'b0100)});
      foreach (s[i]) begin
         drive(s[i]);
         e = exp_q.pop_front();
         vectors++;
         if (obs !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
         end
      end
      drain(p, f, mn, mx, b, d, to);
      vectors++;
      if (to !== 1'b0 || p != 1) begin
         miscompares++;
         $display("FAIL rm_drain: got to=%0d pulses=%0d want 0/1", to, p);
      end
   endtask

   task automatic test_back_to_back();
      step_t s[$];
      step_t e;
      int p, f, mn, mx, b, d;
      bit to;
      s.push_back('{"bb_c1_2",   4'b0100, ex(2, 0, 0, 0, 0, 4'b0001)});
      s.push_back('{"bb_c1_4",   4'b0100, ex(4, 0, 0, 0, 0, 4'b0001)});
      s.push_back('{"bb_ch_5",   4'b1000, ex(5, 0, 0, 0, 0, 4'b0011)});
      s.push_back('{"bb_vend",   4'b0010, ex(0, 1, 0, 0, 0, 4'b0000)});
      s.push_back('{"bb_done_coin", 4'b0100, ex(0, 0, 0, 1, 1, 4'b1000)});
      foreach (s[i]) begin
         drive(s[i]);
         e = exp_q.pop_front();
         vectors++;
         if (obs !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
         end
      end
      drain(p, f, mn, mx, b, d, to);
      vectors++;
      if (to !== 1'b0 || p != 0 || b != BEEP_CYC - 1) begin
         miscompares++;
         $display("FAIL bb_exact_drain: got to=%0d pulses=%0d beeps=%0d want 0/0/%0d",
                  to, p, b, BEEP_CYC - 1);
      end
      s.delete();
      s.push_back('{"bb_next_c1", 4'b0100, ex(2, 0, 0, 0, 0, 4'b0001)});
      s.push_back('{"bb_next_cancel", 4'b0001, ex(2, 0, 0, 0, 0, 4'b0100)});
      foreach (s[i]) begin
         drive(s[i]);
         e = exp_q.pop_front();
         vectors++;
         if (obs !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", e.name, obs, e.val);
         end
      end
      drain(p, f, mn, mx, b, d, to);
      vectors++;
      if (to !== 1'b0 || p != 2 || mn != PAY_GAP) begin
         miscompares++;
         $display("FAIL bb_next_drain: got to=%0d pulses=%0d gap=%0d want 0/2/%0d",
                  to, p, mn, PAY_GAP);
      end
   endtask

   initial begin
      test_reset();
      test_purchase_change();
      test_dual_coin();
      test_overflow();
      test_ceiling();
      test_timeout();
      test_buy_cancel();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/vend_txn_ctrl.md
VEND_TXN_CTRL -- requirements
Module: vend_txn_ctrl

Interface
REQ-001 SHALL have parameter PRICE, default 5, item price in half-units; legal range 1..MAX_CREDIT.
REQ-002 SHALL have parameter MAX_CREDIT, default 15, credit ceiling in half-units; maximum 15 (4-bit credit).
REQ-003 SHALL have parameter IDLE_TO, default 1000, cycles of inactivity in COLLECT before auto-refund.
REQ-004 SHALL have parameter PAY_GAP, default 4, cycles between change pulses; minimum 2.
REQ-005 SHALL have parameter BEEP_CYC, default 8, length of the completion beep in cycles.
REQ-006 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-high reset (1 = reset asserted).
REQ-008 SHALL have port coin_half  input  1  one-cycle pulse, 1 half-unit inserted.
REQ-009 SHALL have port coin_one  input  1  one-cycle pulse, 2 half-units inserted.
REQ-010 SHALL have port buy_p  input  1  one-cycle pulse, purchase request.
REQ-011 SHALL have port cancel_p  input  1  one-cycle pulse, refund request.
REQ-012 SHALL have port credit  output  4  current credit in half-units, registered.
REQ-013 SHALL have port dispense  output  1  one-cycle item-release pulse.
REQ-014 SHALL have port change_p  output  1  one-cycle pulse per half-unit returned.
REQ-015 SHALL have port reject_p  output  1  one-cycle pulse per refused coin.
REQ-016 SHALL have port beep  output  1  completion tone enable.
REQ-017 SHALL have port led  output  4  status: [0] COLLECT, [1] credit>=PRICE, [2] CHANGE, [3] DONE.

Function
REQ-018 SHALL implement states IDLE, COLLECT, VEND, CHANGE, DONE; all outputs registered; each input event takes effect on the next cycle (1-cycle latency).
REQ-019 IDLE: coin -> credit = coin value, go COLLECT; buy_p and cancel_p ignored.
REQ-020 COLLECT: a coin adds its value; if the sum would exceed MAX_CREDIT, credit is unchanged and reject_p pulses.
REQ-021 COLLECT event priority: cancel_p > buy_p > coin; a coin arriving with a winning cancel/buy is refused (reject_p); if both coins arrive together, coin_one wins and coin_half is refused.
REQ-022 COLLECT: buy_p with credit>=PRICE -> VEND; buy_p with credit<PRICE is ignored (no state change, no pulse).
REQ-023 COLLECT: cancel_p -> CHANGE with the full credit as refund.
REQ-024 COLLECT: inactivity counter resets on any coin/buy/cancel; on reaching IDLE_TO cycles it forces CHANGE (refund as cancel).
REQ-025 VEND lasts exactly 1 cycle: dispense=1, credit -= PRICE; next state CHANGE if remainder>0, else DONE.
REQ-026 CHANGE: first change_p 1 cycle after entry, then one every PAY_GAP cycles; each pulse decrements credit by 1 in the same cycle; when credit reaches 0 -> DONE.
REQ-027 DONE: beep=1 for exactly BEEP_CYC cycles, then IDLE with credit 0.
REQ-028 In VEND/CHANGE/DONE every coin is refused with reject_p; buy_p and cancel_p are ignored.
REQ-029 credit SHALL never exceed MAX_CREDIT nor underflow below 0.
REQ-030 led SHALL be derived from registered state/credit and update in the same cycle as the state.

Reset
REQ-031 rst_n=1 SHALL immediately force IDLE, credit=0, dispense=0, change_p=0, reject_p=0, beep=0, led=0, all counters 0, regardless of the clock.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction with no refund pulses; operation resumes on the first clock edge after deassertion.

Verification
REQ-033 coin_one x3 then buy_p (PRICE=5) -> credit 2,4,6; dispense 1 cycle; one change_p; credit 0; beep 8 cycles; IDLE.
REQ-034 coin_half + coin_one on the same cycle in COLLECT at credit 3 -> credit 5, reject_p=1 once.
REQ-035 credit 14, coin_one -> reject_p, credit stays 14; cancel_p -> 14 change_p pulses spaced PAY_GAP=4 apart, then DONE.
REQ-036 credit 4, buy_p -> ignored; no coins for IDLE_TO cycles -> CHANGE, 4 change_p pulses, beep.
REQ-037 buy_p and cancel_p on the same cycle at credit 6 -> cancel wins, no dispense, 6 change_p pulses.
REQ-038 rst_n asserted during CHANGE after 2 of 6 pulses -> outputs 0 asynchronously; after release, IDLE with credit 0 and no further change_p.
